// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one-cycle-latency imem reads, and buffers words in a 2-entry queue.
// Latency: a request in cycle N is captured at the end of N+1, so inst_valid rises in N+2. A redirect costs 2 empty cycles.
// Backpressure: credit-based. At most 2 words are held or in flight, so the queue cannot overflow while inst_ready is low.
// Ports: clk/rst_n (async active-low); imem_req/imem_addr/imem_rdata go to instruction memory;
//        redirect_valid/redirect_pc carry a single-cycle flush and new target;
//        inst_valid/inst_ready/inst/inst_pc/opcode form the decode handshake.
module inst_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      opcode
);

  logic [XLEN-1:0] fetch_pc;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;
  logic            drop;
  logic [1:0]      count;

  // Entry 0 is always the head; a pop shifts entry 1 down.
  logic [XLEN-1:0] q_pc   [2];
  logic [XLEN-1:0] q_word [2];
  logic [XLEN-1:0] q_pc_nxt   [2];
  logic [XLEN-1:0] q_word_nxt [2];
  logic [1:0]      count_nxt;

  logic       pop;
  logic       enq;
  logic [2:0] pending;
  logic [1:0] base;

  assign inst_valid = (count != 2'd0);
  assign pop        = inst_valid && inst_ready;

  // Words held plus the one in flight, less the one leaving this cycle.
  // Issuing only while this is below 2 bounds the queue at 2 entries.
  assign pending   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign imem_req  = rst_n && !redirect_valid && (pending < 3'd2);
  assign imem_addr = fetch_pc;

  // A response landing in a redirect cycle belongs to the old path.
  assign enq = inflight && !drop && !redirect_valid;

  // Slot written by the enqueue after any pop has shifted the queue.
  assign base = count - {1'b0, pop};

  always_comb begin
    q_pc_nxt[0]   = q_pc[0];
    q_pc_nxt[1]   = q_pc[1];
    q_word_nxt[0] = q_word[0];
    q_word_nxt[1] = q_word[1];
    count_nxt     = base + {1'b0, enq};
    if (pop) begin
      q_pc_nxt[0]   = q_pc[1];
      q_word_nxt[0] = q_word[1];
    end
    if (enq) begin
      // The credit rule keeps base at 0 or 1 whenever enq is set.
      if (base[0]) begin
        q_pc_nxt[1]   = inflight_pc;
        q_word_nxt[1] = imem_rdata;
      end else begin
        q_pc_nxt[0]   = inflight_pc;
        q_word_nxt[0] = imem_rdata;
      end
    end
    if (redirect_valid) begin
      count_nxt = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      drop        <= 1'b0;
      count       <= 2'd0;
      q_pc[0]     <= '0;
      q_pc[1]     <= '0;
      q_word[0]   <= '0;
      q_word[1]   <= '0;
    end else begin
      count     <= count_nxt;
      q_pc[0]   <= q_pc_nxt[0];
      q_pc[1]   <= q_pc_nxt[1];
      q_word[0] <= q_word_nxt[0];
      q_word[1] <= q_word_nxt[1];
      inflight  <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
      end
      if (redirect_valid) begin
        // No request goes out during a redirect, so nothing from the old path
        // can still be in flight afterwards; drop is simply cleared here.
        drop     <= 1'b0;
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (imem_req) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
    end
  end

  assign inst    = inst_valid ? q_word[0] : '0;
  assign inst_pc = inst_valid ? q_pc[0]   : '0;
  assign opcode  = inst[6:0];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed vector table, randomized traffic, and a mid-stream reset.
// The reference model tracks the expected instruction stream as address arithmetic.
// It checks the next PC to deliver, the next PC to request, and the cycles since the last restart.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;

  always #5 clk = ~clk;

  inst_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .opcode(opcode)
  );

  // Low bits vary with the address so every opcode bit is exercised.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000 ^ {25'd0, a[8:2]};
  endfunction

  // One-cycle-latency memory that never stalls; junk when not requested.
  always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : $urandom;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_pop_pc;   // PC decode should see next
  logic [31:0] m_req_pc;   // PC fetch should request next
  int          m_age;      // cycles since the last restart (reset release or redirect)

  // Values sampled in the last cycle, for the vector table
  logic        s_req, s_v;
  logic [31:0] s_addr, s_pc;

  task automatic model_reset();
    m_pop_pc = 32'h0;
    m_req_pc = 32'h0;
    m_age    = 0;
  endtask

  // Called #1 after a rising edge; drives inputs, checks mid-cycle, returns #1 after the next edge.
  task automatic cycle(input bit rv, input logic [31:0] rpc, input bit rdy);
    bit pop;
    bit exp_req;
    int outstanding;
    logic [31:0] w;
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    @(negedge clk);
    s_req  = imem_req;
    s_addr = imem_addr;
    s_v    = inst_valid;
    s_pc   = inst_pc;
    pop    = inst_valid && rdy;
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, (m_age >= 2)});
    if (inst_valid) begin
      w = mem_word(m_pop_pc);
      chk("inst_pc", inst_pc, m_pop_pc);
      chk("inst", inst, w);
      chk("opcode", {25'd0, opcode}, {25'd0, w[6:0]});
    end else begin
      chk("inst_idle", inst, 32'h0);
      chk("inst_pc_idle", inst_pc, 32'h0);
      chk("opcode_idle", {25'd0, opcode}, 32'h0);
    end
    // Words requested but not yet handed to decode.
    outstanding = int'((m_req_pc - m_pop_pc) >> 2);
    exp_req = !rv && ((outstanding - int'(pop)) < 2);
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    chk("imem_addr", imem_addr, m_req_pc);
    if (rv) begin
      m_pop_pc = {rpc[31:2], 2'b00};
      m_req_pc = {rpc[31:2], 2'b00};
      m_age    = 0;
    end else begin
      if (pop) m_pop_pc = m_pop_pc + 32'd4;
      if (imem_req) m_req_pc = m_req_pc + 32'd4;
      if (m_age < 1000) m_age++;
    end
    @(posedge clk);
    #1;
  endtask

  // One-cycle reset pulse starting #1 after a rising edge; outputs must clear at once.
  task automatic pulse_reset();
    redirect_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_imem_req", {31'd0, imem_req}, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_opcode", {25'd0, opcode}, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_req", {31'd0, imem_req}, 32'h0);
    chk("rst_hold_valid", {31'd0, inst_valid}, 32'h0);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit          rst;
    bit          rv;
    logic [31:0] rpc;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_v;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // {rst, redirect, target, ready, exp req, exp addr, exp valid, exp pc}
    // Start-up and redirect to 0x100 in cycle 4
    tbl.push_back('{1, 0, 32'h0,         1, 1, 32'h0000_0000, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h0,         1, 1, 32'h0000_0004, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h0,         1, 1, 32'h0000_0008, 1, 32'h0000_0000});
    tbl.push_back('{0, 0, 32'h0,         1, 1, 32'h0000_000C, 1, 32'h0000_0004});
    tbl.push_back('{0, 1, 32'h100,       1, 0, 32'h0000_0010, 1, 32'h0000_0008});
    tbl.push_back('{0, 0, 32'h0,         1, 1, 32'h0000_0100, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h0,         1, 1, 32'h0000_0104, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h0,         1, 1, 32'h0000_0108, 1, 32'h0000_0100});
    tbl.push_back('{0, 0, 32'h0,         1, 1, 32'h0000_010C, 1, 32'h0000_0104});
    // Backpressure from cycle 2 for 5 cycles
    tbl.push_back('{1, 0, 32'h0,         1, 1, 32'h0000_0000, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h0,         1, 1, 32'h0000_0004, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h0,         0, 0, 32'h0000_0008, 1, 32'h0000_0000});
    tbl.push_back('{0, 0, 32'h0,         0, 0, 32'h0000_0008, 1, 32'h0000_0000});
    tbl.push_back('{0, 0, 32'h0,         0, 0, 32'h0000_0008, 1, 32'h0000_0000});
    tbl.push_back('{0, 0, 32'h0,         0, 0, 32'h0000_0008, 1, 32'h0000_0000});
    tbl.push_back('{0, 0, 32'h0,         0, 0, 32'h0000_0008, 1, 32'h0000_0000});
    tbl.push_back('{0, 0, 32'h0,         1, 1, 32'h0000_0008, 1, 32'h0000_0000});
    tbl.push_back('{0, 0, 32'h0,         1, 1, 32'h0000_000C, 1, 32'h0000_0004});
    tbl.push_back('{0, 0, 32'h0,         1, 1, 32'h0000_0010, 1, 32'h0000_0008});
    // Back-to-back redirects 0x200 then 0x300
    tbl.push_back('{0, 1, 32'h200,       1, 0, 32'h0000_0014, 1, 32'h0000_000C});
    tbl.push_back('{0, 1, 32'h300,       1, 0, 32'h0000_0200, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h0,         1, 1, 32'h0000_0300, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h0,         1, 1, 32'h0000_0304, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h0,         1, 1, 32'h0000_0308, 1, 32'h0000_0300});
    // Misaligned redirect
    tbl.push_back('{0, 1, 32'h1003,      1, 0, 32'h0000_030C, 1, 32'h0000_0304});
    tbl.push_back('{0, 0, 32'h0,         1, 1, 32'h0000_1000, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h0,         1, 1, 32'h0000_1004, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h0,         1, 1, 32'h0000_1008, 1, 32'h0000_1000});
    // Address wrap
    tbl.push_back('{0, 1, 32'hFFFF_FFF8, 1, 0, 32'h0000_100C, 1, 32'h0000_1004});
    tbl.push_back('{0, 0, 32'h0,         1, 1, 32'hFFFF_FFF8, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h0,         1, 1, 32'h0000_0000, 1, 32'hFFFF_FFF8});
    tbl.push_back('{0, 0, 32'h0,         1, 1, 32'h0000_0004, 1, 32'hFFFF_FFFC});
    tbl.push_back('{0, 0, 32'h0,         1, 1, 32'h0000_0008, 1, 32'h0000_0000});

    model_reset();
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      if (tbl[i].rst) pulse_reset();
      cycle(tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      chk($sformatf("vec%0d_req", i), {31'd0, s_req}, {31'd0, tbl[i].e_req});
      chk($sformatf("vec%0d_addr", i), s_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_valid", i), {31'd0, s_v}, {31'd0, tbl[i].e_v});
      chk($sformatf("vec%0d_pc", i), s_pc, tbl[i].e_pc);
    end

    // Randomized traffic: sporadic backpressure, redirects incl. misaligned and near-wrap targets
    for (int n = 0; n < 800; n++) begin
      bit          rv;
      bit          rdy;
      logic [31:0] rpc;
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else rpc = $urandom;
      cycle(rv, rpc, rdy);
    end

    // Mid-stream reset with the queue full: fill it, then pulse reset
    cycle(1'b1, 32'h0000_4000, 1'b1);
    for (int n = 0; n < 5; n++) cycle(1'b0, 32'h0, 1'b0);
    chk("full_before_reset", {31'd0, inst_valid}, 32'h1);
    chk("full_req_blocked", {31'd0, imem_req}, 32'h0);
    pulse_reset();
    for (int n = 0; n < 8; n++) begin
      cycle(1'b0, 32'h0, 1'b1);
      if (n == 2) chk("restart_first_pc", s_pc, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
